// File: rtl/sd_route_pkg.sv
// Shared definitions for the SD card router: FSM encoding and route constants.
package sd_route_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StCommit
    } route_state_e;

    localparam int unsigned RouteW  = 3;
    localparam int unsigned ActCntW = 24;

    localparam logic [RouteW-1:0] ROUTE_PHYS      = 3'd0;
    localparam logic [RouteW-1:0] ROUTE_SLOT_BASE = 3'd1;

endpackage

// File: rtl/sd_activity.sv
// SPI activity detector: stays active for TIMEOUT cycles after any toggle on mosi or miso.
module sd_activity
    import sd_route_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic mosi,
    input  logic miso,
    input  logic force_idle,
    output logic act
);

    localparam logic [ActCntW-1:0] Limit = 24'(TIMEOUT);

    logic               mosi_q;
    logic               miso_q;
    logic [ActCntW-1:0] cnt_q;
    logic [ActCntW-1:0] cnt_d;
    logic               toggle;

    assign toggle = (mosi ^ mosi_q) | (miso ^ miso_q);
    assign act    = (cnt_q < Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (force_idle) begin
            cnt_d = Limit;
        end else if (toggle) begin
            cnt_d = '0;
        end else if (cnt_q < Limit) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            mosi_q <= 1'b0;
            miso_q <= 1'b0;
            cnt_q  <= Limit;
        end else begin
            mosi_q <= mosi;
            miso_q <= miso;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_route.sv
// Routes the core's SPI master to the physical SD card or one of NSLOT virtual card images,
// switching only after the bus has been idle (ss high) for GUARD consecutive cycles.
module sd_route
    import sd_route_pkg::*;
#(
    parameter int unsigned NSLOT   = 2,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned GUARD   = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [NSLOT-1:0] img_mounted,
    input  logic [NSLOT-1:0] img_size_nz,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic [NSLOT-1:0] vsd_ss,
    input  logic [NSLOT-1:0] vsd_miso,
    output logic             SD_CS,
    output logic             SD_SCK,
    output logic             SD_MOSI,
    input  logic             SD_MISO,
    output logic [2:0]       sel,
    output logic             switching,
    output logic             act_phys,
    output logic             act_virt
);

    localparam logic [7:0] GuardLast = 8'(GUARD - 1);

    logic [NSLOT-1:0]  valid_q, valid_d;
    route_state_e      state_q, state_d;
    logic [RouteW-1:0] sel_q, sel_d;
    logic [7:0]        gcnt_q, gcnt_d;
    logic              act_phys_q, act_virt_q;
    logic [RouteW-1:0] target;
    logic              act;

    assign valid_d = (valid_q & ~img_mounted) | (img_size_nz & img_mounted);

    // Walk from the top so the lowest-index valid slot wins.
    always_comb begin
        target = ROUTE_PHYS;
        for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
            if (valid_q[i]) begin
                target = ROUTE_SLOT_BASE + 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            StRun: begin
                gcnt_d = '0;
                if (target != sel_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (target == sel_q) begin
                    state_d = StRun;
                    gcnt_d  = '0;
                end else if (!ss) begin
                    gcnt_d = '0;
                end else if (gcnt_q == GuardLast) begin
                    state_d = StCommit;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            StCommit: begin
                sel_d   = target;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            state_q    <= StRun;
            sel_q      <= ROUTE_PHYS;
            gcnt_q     <= '0;
            act_phys_q <= 1'b0;
            act_virt_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            gcnt_q     <= gcnt_d;
            act_phys_q <= act & (sel_q == ROUTE_PHYS);
            act_virt_q <= act & (sel_q != ROUTE_PHYS);
        end
    end

    // The commit cycle parks every card deselected so no half-routed transfer can start.
    always_comb begin
        SD_CS   = 1'b1;
        SD_SCK  = 1'b0;
        SD_MOSI = 1'b0;
        vsd_ss  = '1;
        miso    = SD_MISO;
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (sel_q == ROUTE_SLOT_BASE + 3'(i)) begin
                miso = vsd_miso[i];
            end
        end
        if (state_q != StCommit) begin
            if (sel_q == ROUTE_PHYS) begin
                SD_CS   = ss;
                SD_SCK  = sck;
                SD_MOSI = mosi;
            end else begin
                for (int i = 0; i < int'(NSLOT); i++) begin
                    if (sel_q == ROUTE_SLOT_BASE + 3'(i)) begin
                        vsd_ss[i] = ss;
                    end
                end
            end
        end
    end

    sd_activity #(
        .TIMEOUT(TIMEOUT)
    ) u_activity (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .mosi      (mosi),
        .miso      (miso),
        .force_idle(state_q == StCommit),
        .act       (act)
    );

    assign sel       = sel_q;
    assign switching = (state_q != StRun);
    assign act_phys  = act_phys_q;
    assign act_virt  = act_virt_q;

endmodule

// File: tb/tb_sd_route.sv
// Self-checking bench for sd_route: routing table, directed switch/timeout sequences and
// randomized traffic compared each cycle against a behavioural model.
module tb_sd_route;

    localparam int NS = 3;
    localparam int TO = 16;
    localparam int GD = 8;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b0;
    logic [NS-1:0] img_mounted = '0;
    logic [NS-1:0] img_size_nz = '0;
    logic          sck = 1'b0;
    logic          ss = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [NS-1:0] vsd_ss;
    logic [NS-1:0] vsd_miso = '0;
    logic          SD_CS, SD_SCK, SD_MOSI;
    logic          SD_MISO = 1'b0;
    logic [2:0]    sel;
    logic          switching, act_phys, act_virt;

    sd_route #(
        .NSLOT  (NS),
        .TIMEOUT(TO),
        .GUARD  (GD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .img_mounted(img_mounted),
        .img_size_nz(img_size_nz),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .vsd_ss     (vsd_ss),
        .vsd_miso   (vsd_miso),
        .SD_CS      (SD_CS),
        .SD_SCK     (SD_SCK),
        .SD_MOSI    (SD_MOSI),
        .SD_MISO    (SD_MISO),
        .sel        (sel),
        .switching  (switching),
        .act_phys   (act_phys),
        .act_virt   (act_virt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mounted set, pending switch with ss-high run length, idle cycle count.
    bit m_valid[NS];
    int m_sel;
    bit m_pending;
    int m_run;
    bit m_commit;
    int m_since;
    bit m_act_phys, m_act_virt;
    bit m_prev_mosi, m_prev_miso;

    function automatic int lowest_target();
        for (int i = 0; i < NS; i++) if (m_valid[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic exp_miso();
        logic [NS-1:0] v;
        v = vsd_miso;
        if (m_sel == 0) return SD_MISO;
        return v[m_sel-1];
    endfunction

    function automatic logic [NS-1:0] exp_vss();
        logic [NS-1:0] v;
        v = '1;
        if (!m_commit && m_sel != 0) begin
            for (int i = 0; i < NS; i++) if (m_sel == i + 1) v[i] = ss;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        m_sel = 0; m_pending = 0; m_run = 0; m_commit = 0; m_since = TO;
        m_act_phys = 0; m_act_virt = 0; m_prev_mosi = 0; m_prev_miso = 0;
    endtask

    task automatic model_step();
        int  tgt;
        bit  mi, tog;
        tgt = lowest_target();
        mi  = exp_miso();
        tog = (mosi != m_prev_mosi) || (mi != m_prev_miso);
        m_act_phys = (m_since < TO) && (m_sel == 0);
        m_act_virt = (m_since < TO) && (m_sel != 0);
        m_prev_mosi = mosi;
        m_prev_miso = mi;
        if (m_commit) m_since = TO;
        else if (tog) m_since = 0;
        else if (m_since < TO) m_since++;
        if (m_commit) begin
            m_sel = tgt;
            m_commit = 0;
        end else if (!m_pending) begin
            if (tgt != m_sel) begin
                m_pending = 1;
                m_run = 0;
            end
        end else if (tgt == m_sel) begin
            m_pending = 0;
        end else if (ss) begin
            m_run++;
            if (m_run == GD) begin
                m_pending = 0;
                m_commit = 1;
            end
        end else begin
            m_run = 0;
        end
        for (int i = 0; i < NS; i++) if (img_mounted[i]) m_valid[i] = img_size_nz[i];
    endtask

    task automatic check_all();
        bit idle_route;
        idle_route = m_commit || (m_sel != 0);
        check("sel", 8'(sel), 8'(m_sel));
        check("switching", 8'(switching), 8'(m_pending || m_commit));
        check("act_phys", 8'(act_phys), 8'(m_act_phys));
        check("act_virt", 8'(act_virt), 8'(m_act_virt));
        check("SD_CS", 8'(SD_CS), idle_route ? 8'd1 : 8'(ss));
        check("SD_SCK", 8'(SD_SCK), idle_route ? 8'd0 : 8'(sck));
        check("SD_MOSI", 8'(SD_MOSI), idle_route ? 8'd0 : 8'(mosi));
        check("miso", 8'(miso), 8'(exp_miso()));
        check("vsd_ss", 8'(vsd_ss), 8'(exp_vss()));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (reset) model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [2:0] mnt, nz;
        logic       sck, ss, mosi, sdmiso;
        logic [2:0] vmiso;
        logic [2:0] e_sel;
        logic       e_cs, e_sck, e_mosi, e_miso;
        logic [2:0] e_vss;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sw;
        int cnt;
        vecs[0] = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'd0,
                    1'b0, 1'b1, 1'b1, 1'b1, 3'b111};
        vecs[1] = '{3'b001, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 3'd1,
                    1'b1, 1'b0, 1'b0, 1'b0, 3'b110};
        vecs[2] = '{3'b110, 3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 3'd1,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'b111};
        vecs[3] = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 3'd2,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'b101};
        vecs[4] = '{3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 3'd3,
                    1'b1, 1'b0, 1'b0, 1'b0, 3'b011};
        vecs[5] = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 3'b111};
        vecs[6] = '{3'b011, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 3'd1,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'b110};

        // Reset state and routing table.
        do_reset();
        for (int r = 0; r < 7; r++) begin
            ss = 1'b1; sck = 1'b0; mosi = 1'b0;
            img_mounted = vecs[r].mnt;
            img_size_nz = vecs[r].nz;
            tick();
            img_mounted = '0;
            repeat (14) tick();
            sck = vecs[r].sck; ss = vecs[r].ss; mosi = vecs[r].mosi;
            SD_MISO = vecs[r].sdmiso; vsd_miso = vecs[r].vmiso;
            #1;
            check("tbl_sel", 8'(sel), 8'(vecs[r].e_sel));
            check("tbl_cs", 8'(SD_CS), 8'(vecs[r].e_cs));
            check("tbl_sck", 8'(SD_SCK), 8'(vecs[r].e_sck));
            check("tbl_mosi", 8'(SD_MOSI), 8'(vecs[r].e_mosi));
            check("tbl_miso", 8'(miso), 8'(vecs[r].e_miso));
            check("tbl_vss", 8'(vsd_ss), 8'(vecs[r].e_vss));
            tick();
        end

        // Mount while idle: switching window is GUARD+1 cycles.
        ss = 1'b1; mosi = 1'b0; sck = 1'b0; SD_MISO = 1'b0; vsd_miso = '0;
        do_reset();
        img_mounted = 3'b001; img_size_nz = 3'b001;
        tick();
        img_mounted = '0;
        sw = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (switching === 1'b1) sw++;
        end
        check("idle_guard_window", 8'(sw), 8'(GD + 1));
        check("idle_sel", 8'(sel), 8'd1);
        ss = 1'b0;
        #1;
        check("idle_vss0_follows", 8'(vsd_ss[0]), 8'd0);
        check("idle_sd_cs", 8'(SD_CS), 8'd1);

        // Mount mid-transaction; a short idle gap must not commit.
        do_reset();
        ss = 1'b0;
        img_mounted = 3'b001; img_size_nz = 3'b001;
        tick();
        img_mounted = '0;
        repeat (100) tick();
        check("mid_hold_sel", 8'(sel), 8'd0);
        check("mid_hold_sw", 8'(switching), 8'd1);
        ss = 1'b1; repeat (3) tick();
        ss = 1'b0; repeat (5) tick();
        check("mid_gap_sel", 8'(sel), 8'd0);
        ss = 1'b1; repeat (8) tick();
        check("mid_commit_sel", 8'(sel), 8'd0);
        check("mid_commit_cs", 8'(SD_CS), 8'd1);
        tick();
        check("mid_done_sel", 8'(sel), 8'd1);
        check("mid_done_sw", 8'(switching), 8'd0);

        // Mount cancelled before commit.
        do_reset();
        ss = 1'b1;
        img_mounted = 3'b001; img_size_nz = 3'b001;
        tick();
        img_mounted = '0;
        tick(); tick();
        img_mounted = 3'b001; img_size_nz = 3'b000;
        tick();
        img_mounted = '0;
        tick();
        check("cancel_sw", 8'(switching), 8'd0);
        sw = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (switching === 1'b1 || sel !== 3'd0) sw++;
        end
        check("cancel_no_commit", 8'(sw), 8'd0);

        // Activity timeout and asynchronous reset.
        do_reset();
        ss = 1'b1; mosi = 1'b0; SD_MISO = 1'b0;
        tick();
        mosi = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 1) check("act_within_2", 8'(act_phys), 8'd1);
            if (act_phys === 1'b1) cnt++;
        end
        check("act_duration", 8'(cnt), 8'(TO));
        mosi = 1'b0;
        repeat (5) tick();
        check("act_mid", 8'(act_phys), 8'd1);
        reset = 1'b0;
        model_reset();
        #1;
        check("act_reset_async", 8'(act_phys), 8'd0);
        check_all();
        tick();
        reset = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ss = ~ss;
            sck = 1'($urandom);
            if ($urandom_range(0, 7) == 0) mosi = ~mosi;
            if ($urandom_range(0, 15) == 0) SD_MISO = ~SD_MISO;
            if ($urandom_range(0, 15) == 0) vsd_miso = 3'($urandom);
            img_mounted = '0;
            if ($urandom_range(0, 39) == 0) begin
                img_mounted = 3'($urandom);
                img_size_nz = 3'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check_all();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_route.md
SD_ROUTE -- requirements
Module: sd_route

Interface
REQ-001 Parameter NSLOT, default 2, number of virtual SD image slots, legal range 1..7.
REQ-002 Parameter TIMEOUT, default 1000000, activity hold time in clk_sys cycles, legal range 1..2^24-1.
REQ-003 Parameter GUARD, default 8, consecutive ss-high cycles required before a route switch, legal range 1..255.
REQ-004 clk_sys  in  1  system clock; all state is rising-edge clocked.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 img_mounted  in  NSLOT  per-slot one-cycle mount pulse.
REQ-007 img_size_nz  in  NSLOT  per-slot flag, high when the image size is non-zero; sampled with img_mounted.
REQ-008 sck, ss, mosi  in  1 each  core SPI master signals; ss is active-low.
REQ-009 miso  out  1  routed SPI data to the core.
REQ-010 vsd_ss  out  NSLOT  active-low selects to the virtual card instances.
REQ-011 vsd_miso  in  NSLOT  virtual card data outputs.
REQ-012 SD_CS, SD_SCK, SD_MOSI  out  1 each  physical card pins; SD_MISO  in  1.
REQ-013 sel  out  3  current route: 0 = physical card, k = virtual slot k-1.
REQ-014 switching  out  1  high while a route change is pending or committing.
REQ-015 act_phys, act_virt  out  1 each  activity indicators.

Function
REQ-016 valid[i] SHALL load img_size_nz[i] on any cycle where img_mounted[i]=1; slots update independently, including simultaneous mounts.
REQ-017 The target route SHALL be 1 + the lowest-index set valid bit, or 0 when no bit is set; it is combinational from valid.
REQ-018 FSM states: RUN, DRAIN, COMMIT.
REQ-019 RUN: transition to DRAIN when target != sel.
REQ-020 DRAIN: count consecutive cycles with ss=1; the count clears on ss=0.
REQ-021 DRAIN: return to RUN when target == sel again; move to COMMIT when the count reaches GUARD.
REQ-022 COMMIT: sel <= target, return to RUN next cycle; the commit lasts exactly one cycle.
REQ-023 switching SHALL be 1 in DRAIN and COMMIT, and 0 in RUN.
REQ-024 Routing is combinational from sel and state.
REQ-025 sel=0: SD_CS=ss, SD_SCK=sck, SD_MOSI=mosi, miso=SD_MISO, all vsd_ss=1.
REQ-026 sel=k: SD_CS=1, SD_SCK=0, SD_MOSI=0, vsd_ss[k-1]=ss, other vsd_ss=1, miso=vsd_miso[k-1].
REQ-027 In COMMIT: SD_CS=1, all vsd_ss=1, SD_SCK=0, SD_MOSI=0.
REQ-028 A transaction in progress (ss=0) SHALL never be rerouted.
REQ-029 Activity detection: registered copies of mosi and miso; any toggle on either SHALL clear a 24-bit counter to 0.
REQ-030 Without a toggle, the counter increments and saturates at TIMEOUT.
REQ-031 COMMIT SHALL force the counter to TIMEOUT.
REQ-032 act = (counter < TIMEOUT); act_phys = act & (sel==0); act_virt = act & (sel!=0); both outputs are registered, with one cycle latency after the counter.
REQ-033 A sel value above NSLOT is unreachable; no out-of-range slot index SHALL be produced.

Reset
REQ-034 On reset low, the following SHALL take their reset values asynchronously:
- valid=0, sel=0, state=RUN, guard count=0;
- counter=TIMEOUT, act_phys=0, act_virt=0, switching=0;
- registered mosi/miso copies=0.
REQ-035 While in reset, outputs SHALL follow the sel=0 routing, so the physical card passes through.
REQ-036 Reset asserted in DRAIN or COMMIT SHALL abandon the switch, with no partial sel update.
REQ-037 Release of reset is synchronised by the integrator; no internal synchroniser is included.

Structure
REQ-038 The state encoding and the route constants (ROUTE_PHYS=0, slot base=1) SHALL be defined in shared package sd_route_pkg.
REQ-039 The activity detector SHALL be a sub-module sd_activity (clk_sys, reset, mosi, miso, TIMEOUT parameter, act output), reusable for other LED indicators.
REQ-040 The routing mux and FSM SHALL reside in sd_route.

Verification
REQ-041 Physical routing: reset release, no mounts, toggle sck/mosi -> sel=0, SD_SCK mirrors sck, all vsd_ss=1, act_phys=1 within 2 cycles of the first mosi toggle.
REQ-042 Mount while idle: img_mounted=01, img_size_nz=01, ss=1 held -> switching=1 for GUARD+1 cycles, then sel=1, SD_CS=1, vsd_ss[0] follows ss.
REQ-043 Mount mid-transaction: ss=0 for 100 cycles when slot 0 mounts -> sel stays 0 until ss has been high for 8 consecutive cycles, then commits; a 3-cycle ss-high gap SHALL NOT commit.
REQ-044 Mount cancel: slot 0 mounts, then before commit is unmounted (img_size_nz=0) -> FSM returns to RUN with sel=0 and no COMMIT cycle.
REQ-045 Priority and simultaneity: slots 0 and 1 mount in the same cycle -> sel=1; later unmount slot 0 -> sel=2 after drain.
REQ-046 Timeout: TIMEOUT=16, a single mosi toggle -> act high for exactly 16 cycles, then 0; reset asserted mid-count -> act=0 immediately.
